prio_q_kv: RTL and testbench

- Parametrised successor to the single-field min-priority queue used by the PDES event engine.
- Stores (key, payload) pairs: key is the event timestamp, payload is the event descriptor.
- Always presents the minimum-key entry at its head.
- Adds the following over the previous generation:
  - single-cycle simultaneous enqueue+dequeue (replace);
  - stable FIFO ordering among equal keys;
  - explicit full/empty status;
  - sticky overflow/underflow error flags.

---
 rtl/prio_q_kv_if.sv | 35 +++
 rtl/prio_q_kv.sv | 131 +++++++++++++
 tb/tb_prio_q_kv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/prio_q_kv_if.sv
// prio_q_kv_if: bundles the command and status signals of the prio_q_kv
// sorted priority queue.
//   master modport (queue user): drives enq, deq, inp_key, inp_pay, clr_err;
//                                observes out_key, out_pay, out_valid, count,
//                                full, empty, err_ovf, err_udf.
//   slave modport (the queue):   the mirror image of master.
interface prio_q_kv_if #(
  parameter int KEY_W      = 16,
  parameter int PAY_W      = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  enq;
  logic                  deq;
  logic                  clr_err;
  logic [KEY_W-1:0]      inp_key;
  logic [PAY_W-1:0]      inp_pay;
  logic [KEY_W-1:0]      out_key;
  logic [PAY_W-1:0]      out_pay;
  logic                  out_valid;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output enq, deq, clr_err, inp_key, inp_pay,
    input  out_key, out_pay, out_valid, count, full, empty, err_ovf, err_udf
  );

  modport slave (
    input  enq, deq, clr_err, inp_key, inp_pay,
    output out_key, out_pay, out_valid, count, full, empty, err_ovf, err_udf
  );
endinterface

// File: rtl/prio_q_kv.sv
// prio_q_kv: min-priority queue of (key, payload) pairs held in a sorted
// register array. slot[0] always holds the smallest key and drives the head
// outputs directly. Equal keys leave in arrival order.
// Ports:
//   CLK    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears all contents and flags
//   bus    - prio_q_kv_if.slave: enq/deq/clr_err commands, inp_key/inp_pay
//            insert data, out_key/out_pay/out_valid head, count/full/empty
//            status, sticky err_ovf/err_udf flags
module prio_q_kv #(
  parameter int KEY_W      = 16,
  parameter int PAY_W      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        CLK,
  input  logic        rst_n,
  prio_q_kv_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [KEY_W-1:0] key_q    [DEPTH];
  logic [KEY_W-1:0] key_d    [DEPTH];
  logic [KEY_W-1:0] base_key [DEPTH];
  logic [PAY_W-1:0] pay_q    [DEPTH];
  logic [PAY_W-1:0] pay_d    [DEPTH];
  logic [PAY_W-1:0] base_pay [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] base_vld;
  logic [DEPTH-1:0] le;
  logic [DEPTH-1:0] take_new;
  logic [DEPTH-1:0] take_prev;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_ovf_q;
  logic             err_ovf_d;
  logic             err_udf_q;
  logic             err_udf_d;

  logic full_w;
  logic empty_w;
  logic do_enq;
  logic do_deq;
  logic ovf_set;
  logic udf_set;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // A deq frees the slot an enq needs, so a full queue still accepts a
  // simultaneous enq+deq. A deq on an empty queue is ignored.
  assign do_deq  = bus.deq && !empty_w;
  assign do_enq  = bus.enq && (!full_w || bus.deq);
  assign ovf_set = bus.enq && full_w && !bus.deq;
  assign udf_set = bus.deq && empty_w;

  assign count_d   = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
  // A same-cycle error event wins over the clear.
  assign err_ovf_d = ovf_set || (err_ovf_q && !bus.clr_err);
  assign err_udf_d = udf_set || (err_udf_q && !bus.clr_err);

  // Two-stage update per slot: first the optional shift-down for deq
  // (base_*), then the insertion into that base array. Empty slots are kept
  // at zero so the head reads 0 whenever the queue is empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi < DEPTH - 1) begin : g_base_mid
      assign base_key[gi] = do_deq ? key_q[gi+1] : key_q[gi];
      assign base_pay[gi] = do_deq ? pay_q[gi+1] : pay_q[gi];
      assign base_vld[gi] = do_deq ? vld_q[gi+1] : vld_q[gi];
    end else begin : g_base_top
      assign base_key[gi] = do_deq ? '0 : key_q[gi];
      assign base_pay[gi] = do_deq ? '0 : pay_q[gi];
      assign base_vld[gi] = do_deq ? 1'b0 : vld_q[gi];
    end

    // Entries with key <= new key stay in place; the new entry lands just
    // after the last of them, which keeps equal keys in FIFO order. Since
    // the array is sorted, le is a run of ones starting at slot 0.
    assign le[gi] = base_vld[gi] && (base_key[gi] <= bus.inp_key);

    if (gi == 0) begin : g_ins_head
      assign take_new[gi]  = do_enq && !le[gi];
      assign take_prev[gi] = 1'b0;
      assign key_d[gi] = take_new[gi] ? bus.inp_key : base_key[gi];
      assign pay_d[gi] = take_new[gi] ? bus.inp_pay : base_pay[gi];
      assign vld_d[gi] = take_new[gi] | base_vld[gi];
    end else begin : g_ins_body
      assign take_new[gi]  = do_enq && !le[gi] && le[gi-1];
      assign take_prev[gi] = do_enq && !le[gi] && !le[gi-1];
      assign key_d[gi] = take_new[gi]  ? bus.inp_key    :
                         take_prev[gi] ? base_key[gi-1] : base_key[gi];
      assign pay_d[gi] = take_new[gi]  ? bus.inp_pay    :
                         take_prev[gi] ? base_pay[gi-1] : base_pay[gi];
      assign vld_d[gi] = take_new[gi]  ? 1'b1           :
                         take_prev[gi] ? base_vld[gi-1] : base_vld[gi];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        pay_q[i] <= '0;
      end
      vld_q     <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= key_d[i];
        pay_q[i] <= pay_d[i];
      end
      vld_q     <= vld_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign bus.out_key   = key_q[0];
  assign bus.out_pay   = pay_q[0];
  assign bus.out_valid = vld_q[0];
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_udf   = err_udf_q;
endmodule

// File: tb/tb_prio_q_kv.sv
module tb_prio_q_kv;
  localparam int KW = 16;
  localparam int PW = 16;
  localparam int DL = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prio_q_kv_if #(.KEY_W(KW), .PAY_W(PW), .DEPTH_LOG2(DL)) bus ();

  prio_q_kv #(.KEY_W(KW), .PAY_W(PW), .DEPTH_LOG2(DL)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [KW+PW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c,
                      input logic [KW-1:0] k, input logic [PW-1:0] p);
    @(negedge clk);
    bus.enq = e; bus.deq = d; bus.clr_err = c; bus.inp_key = k; bus.inp_pay = p;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic enq(input logic [KW-1:0] k, input logic [PW-1:0] p);
    step(1'b1, 1'b0, 1'b0, k, p);
  endtask

  // deq with the hand-computed value that should leave the head
  task automatic deq_exp(input logic [KW-1:0] k, input logic [PW-1:0] p);
    exp_q.push_back({k, p});
    step(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: just before each rising edge, a deq with a valid head means the
  // head is leaving; compare it with the oldest scoreboard entry.
  initial begin
    logic [KW+PW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (bus.deq && bus.out_valid) begin
        $display("deq key=%0d pay=%0h", bus.out_key, bus.out_pay);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected: got key %0d, required no output", bus.out_key);
        end else begin
          e = exp_q.pop_front();
          chk("deq_key", 32'(bus.out_key), 32'(e[KW+PW-1:PW]));
          chk("deq_pay", 32'(bus.out_pay), 32'(e[PW-1:0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.enq = 1'b0; bus.deq = 1'b0; bus.clr_err = 1'b0;
    bus.inp_key = '0; bus.inp_pay = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rst_count",   32'(bus.count), 0);
    chk("rst_empty",   32'(bus.empty), 1);
    chk("rst_full",    32'(bus.full), 0);
    chk("rst_valid",   32'(bus.out_valid), 0);
    chk("rst_key",     32'(bus.out_key), 0);
    chk("rst_pay",     32'(bus.out_pay), 0);
    chk("rst_ovf",     32'(bus.err_ovf), 0);
    chk("rst_udf",     32'(bus.err_udf), 0);

    // basic sort
    enq(12, 1); enq(6, 2); enq(97, 3); enq(33, 4);
    idle();
    chk("sort_count", 32'(bus.count), 4);
    chk("sort_head",  32'(bus.out_key), 6);
    deq_exp(6, 2); deq_exp(12, 1); deq_exp(33, 4); deq_exp(97, 3);
    idle();
    chk("sort_count_end", 32'(bus.count), 0);
    chk("sort_empty_end", 32'(bus.empty), 1);

    // stable ties
    enq(25, 16'hA); enq(25, 16'hB); enq(25, 16'hC); enq(20, 16'hD);
    deq_exp(20, 16'hD); deq_exp(25, 16'hA); deq_exp(25, 16'hB); deq_exp(25, 16'hC);
    idle();

    // fill to capacity
    for (int i = 1; i <= 8; i++) enq(16'(10 * i), 16'(i));
    idle();
    chk("fill_count", 32'(bus.count), 8);
    chk("fill_full",  32'(bus.full), 1);
    enq(5, 16'h55);
    idle();
    chk("ovf_flag",  32'(bus.err_ovf), 1);
    chk("ovf_head",  32'(bus.out_key), 10);
    chk("ovf_count", 32'(bus.count), 8);
    exp_q.push_back({16'd10, 16'd1});
    step(1'b1, 1'b1, 1'b0, 5, 16'h55);
    idle();
    chk("repl_head",  32'(bus.out_key), 5);
    chk("repl_pay",   32'(bus.out_pay), 32'h55);
    chk("repl_count", 32'(bus.count), 8);
    chk("repl_full",  32'(bus.full), 1);
    chk("repl_ovf_kept", 32'(bus.err_ovf), 1);
    deq_exp(5, 16'h55);
    for (int i = 2; i <= 8; i++) deq_exp(16'(10 * i), 16'(i));
    idle();
    chk("drain_empty", 32'(bus.empty), 1);

    // underflow
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle();
    chk("udf_flag",  32'(bus.err_udf), 1);
    chk("udf_count", 32'(bus.count), 0);
    step(1'b1, 1'b1, 1'b0, 7, 16'h77);
    idle();
    chk("emptyrepl_count", 32'(bus.count), 1);
    chk("emptyrepl_head",  32'(bus.out_key), 7);
    chk("emptyrepl_valid", 32'(bus.out_valid), 1);

    // clear sticky flags
    step(1'b0, 1'b0, 1'b1, '0, '0);
    idle();
    chk("clr_ovf", 32'(bus.err_ovf), 0);
    chk("clr_udf", 32'(bus.err_udf), 0);

    // asynchronous reset mid-operation
    enq(40, 1); enq(3, 2); enq(50, 3);
    idle();
    chk("pre_rst_count", 32'(bus.count), 4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_key",   32'(bus.out_key), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    #1 rst_n = 1'b1;
    idle();
    chk("post_rst_count", 32'(bus.count), 0);
    enq(9, 16'h99);
    idle();
    chk("post_rst_head",  32'(bus.out_key), 9);
    chk("post_rst_count1", 32'(bus.count), 1);
    deq_exp(9, 16'h99);
    idle();
    idle();
    chk("sb_left", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
